instr_fetch_unit: RTL and testbench

//  Instruction fetch front-end: the producer of the 32-bit instruction word that unit_control decodes.
//  It owns the PC and issues in-order reads to instruction memory over a req/gnt/rvalid port.
//  It buffers returned words in a small prefetch FIFO and presents {instr, instr_pc} to decode

---
 rtl/instr_fetch_unit_pkg.sv | 14 +
 rtl/instr_fetch_unit_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package instr_fetch_unit_pkg;

   localparam int unsigned INSTR_W          = 32;
   localparam int unsigned DEFAULT_RESET_PC = 0;

   // Fetch control FSM
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } if_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO: synchronous, registered head, occupancy count, sync clear, async reset.
module instr_fetch_unit_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         clr,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   // A push into a full FIFO is accepted only when the head leaves in the same cycle
   always_comb begin
      do_pop  = pop & (count_q != '0);
      do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
   end

   // Storage, pointers and occupancy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign valid = (count_q != '0);
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues in-order reads, buffers words for decode,
// and flushes/refetches on a taken branch.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned    AW       = 32,
   parameter int unsigned    DEPTH    = 2,
   parameter logic [AW-1:0]  RESET_PC = AW'(DEFAULT_RESET_PC)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               fetch_en,
   output logic               im_req,
   output logic [AW-1:0]      im_addr,
   input  logic               im_gnt,
   input  logic               im_rvalid,
   input  logic [31:0]        im_rdata,
   output logic [31:0]        instr,
   output logic [AW-1:0]      instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [AW-1:0]      redirect_pc
);

   localparam int unsigned  CW      = $clog2(DEPTH + 1);
   localparam int unsigned  FW      = INSTR_W + AW;
   localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] fifo_count;
   logic [FW-1:0] fifo_rdata;
   if_state_e     state_q, state_d;
   logic          grant, rsp_acc, push, pop, room;

   // Handshake decode. A slot freed by this cycle's pop counts as room, so a full pipe
   // sustains one instruction per cycle. Nothing is requested while reset is held.
   always_comb begin
      pop     = instr_valid & instr_ready;
      rsp_acc = im_rvalid & (inflight_q != '0);
      push    = rsp_acc & (drop_cnt_q == '0) & ~redirect;
      room    = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (DEPTH_W + {{CW{1'b0}}, pop});
      im_req  = fetch_en & ~RST & room & ~redirect;
      im_addr = pc_q;
      grant   = im_req & im_gnt;
   end

   // PC, response PC, outstanding and to-be-discarded counters
   always_comb begin
      pc_d       = pc_q;
      resp_pc_d  = resp_pc_q;
      drop_cnt_d = drop_cnt_q;
      inflight_d = inflight_q + CW'(grant) - CW'(rsp_acc);
      if (grant) begin
         pc_d = pc_q + AW'(1);
      end
      if (redirect) begin
         pc_d      = redirect_pc;
         resp_pc_d = redirect_pc;
         // Every request still outstanding after this edge belongs to the old stream
         drop_cnt_d = inflight_q - CW'(rsp_acc);
      end else begin
         if (rsp_acc && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + AW'(1);
         end
      end
   end

   // Fetch control FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (redirect && (drop_cnt_d != '0)) begin
               state_d = StDrain;
            end else if (fetch_en) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (redirect && (drop_cnt_d != '0)) begin
               state_d = StDrain;
            end else if (!fetch_en) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            if (drop_cnt_d == '0) begin
               state_d = fetch_en ? StRun : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         state_q    <= StIdle;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         state_q    <= state_d;
      end
   end

   instr_fetch_unit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (redirect),
      .push  (push),
      .wdata ({im_rdata, resp_pc_q}),
      .pop   (pop),
      .rdata (fifo_rdata),
      .valid (instr_valid),
      .count (fifo_count)
   );

   assign instr    = fifo_rdata[FW-1:AW];
   assign instr_pc = fifo_rdata[AW-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table, hand sequences, random traffic.
module tb_instr_fetch_unit;
   import instr_fetch_unit_pkg::*;

   localparam int unsigned   AW       = 8;
   localparam int unsigned   DEPTH    = 2;
   localparam logic [AW-1:0] RESET_PC = '0;

   logic          CLK, RST, fetch_en, im_req, im_gnt, im_rvalid;
   logic          instr_valid, instr_ready, redirect;
   logic [AW-1:0] im_addr, instr_pc, redirect_pc;
   logic [31:0]   im_rdata, instr;

   instr_fetch_unit #(
      .AW       (AW),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .fetch_en    (fetch_en),
      .im_req      (im_req),
      .im_addr     (im_addr),
      .im_gnt      (im_gnt),
      .im_rvalid   (im_rvalid),
      .im_rdata    (im_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory requests outstanding (in order) and words the decoder should see (in order)
   typedef struct { logic [AW-1:0] addr; logic [31:0] word; int due; bit stale; } req_t;
   typedef struct { logic [AW-1:0] pc; logic [31:0] word; } ent_t;
   typedef struct { bit fe; bit rdy; bit ev; logic [AW-1:0] epc; bit ereq; logic [AW-1:0] eaddr; } vec_t;

   req_t          mq[$];
   ent_t          fq[$];
   logic [AW-1:0] popped[$];
   logic [AW-1:0] issue_pc;
   logic [31:0]   salt;
   int            cyc, lat, n_cmp, n_err, n_old, k;
   bit            gnt_rand, spur;
   logic          s_valid, s_req;
   logic [AW-1:0] s_pc, s_addr;
   logic [31:0]   s_instr;
   vec_t          tbl[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic vec_t vec(input bit fe, input bit rdy, input bit ev, input int epc,
                                input bit ereq, input int eaddr);
      vec_t v;
      v.fe = fe; v.rdy = rdy; v.ev = ev; v.epc = AW'(epc); v.ereq = ereq; v.eaddr = AW'(eaddr);
      return v;
   endfunction

   function automatic logic [AW-1:0] pop_at(input int i);
      if (i < popped.size()) return popped[i];
      return 'x;
   endfunction

   // One clock cycle: drive inputs, check outputs against the model, advance the model
   task automatic cycle(input bit fe, input bit rdy, input bit rd, input logic [AW-1:0] rpc);
      bit   pop_m, req_m;
      req_t r;
      fetch_en = fe; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
      im_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         im_rvalid = 1'b1;
         im_rdata  = mq[0].word;
      end else begin
         im_rvalid = spur && (mq.size() == 0);
         im_rdata  = $urandom;
      end
      #1;
      s_valid = instr_valid; s_pc = instr_pc; s_instr = instr; s_req = im_req; s_addr = im_addr;
      chk("instr_valid", instr_valid, fq.size() > 0);
      if (fq.size() > 0) begin
         chk("instr_pc", instr_pc, fq[0].pc);
         chk("instr", instr, fq[0].word);
      end
      pop_m = (fq.size() > 0) && rdy;
      req_m = fe && !rd && ((fq.size() + mq.size() - int'(pop_m)) < DEPTH);
      chk("im_req", im_req, req_m);
      if (req_m) chk("im_addr", im_addr, issue_pc);
      chk("drop_bound", dut.drop_cnt_q <= DEPTH, 1);
      if (instr_valid && rdy) popped.push_back(instr_pc);
      if (pop_m && !rd) void'(fq.pop_front());
      if (im_rvalid && mq.size() > 0) begin
         r = mq.pop_front();
         if (!r.stale && !rd) fq.push_back('{pc: r.addr, word: r.word});
      end
      if (im_req && im_gnt) begin
         mq.push_back('{addr: im_addr, word: 32'(im_addr) ^ salt, due: cyc + lat, stale: 1'b0});
         issue_pc = issue_pc + AW'(1);
      end
      if (rd) begin
         fq.delete();
         foreach (mq[i]) mq[i].stale = 1'b1;
         issue_pc = rpc;
      end
      @(negedge CLK);
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; lat = 1; gnt_rand = 0; spur = 0; salt = '0;
      issue_pc = RESET_PC;
      RST = 1'b1; fetch_en = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;

      // Reset state (fetch_en held high to show no request leaks out under reset)
      @(negedge CLK);
      chk("rst_im_req", im_req, 0);
      chk("rst_im_addr", im_addr, RESET_PC);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_instr_valid", instr_valid, 0);
      @(negedge CLK);
      RST = 1'b0;

      // Streaming with a 5-cycle decode stall, 1-cycle memory, word == address
      tbl[0]  = vec(1, 1, 0, 0, 1, 0);
      tbl[1]  = vec(1, 1, 0, 0, 1, 1);
      tbl[2]  = vec(1, 0, 1, 0, 0, 2);
      tbl[3]  = vec(1, 0, 1, 0, 0, 2);
      tbl[4]  = vec(1, 0, 1, 0, 0, 2);
      tbl[5]  = vec(1, 0, 1, 0, 0, 2);
      tbl[6]  = vec(1, 0, 1, 0, 0, 2);
      tbl[7]  = vec(1, 1, 1, 0, 1, 2);
      tbl[8]  = vec(1, 1, 1, 1, 1, 3);
      tbl[9]  = vec(1, 1, 1, 2, 1, 4);
      tbl[10] = vec(1, 1, 1, 3, 1, 5);
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].fe, tbl[i].rdy, 1'b0, '0);
         chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].ev);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_instr", i), s_instr, 32'(tbl[i].epc));
         end
         chk($sformatf("tbl%0d_req", i), s_req, tbl[i].ereq);
         chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
      end

      // Redirect with a full FIFO: output drops the next cycle even though ready is low
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
      cycle(1, 0, 1, 8'h20);
      popped.delete();
      cycle(1, 1, 0, '0);
      chk("t3a_valid_after_redirect", s_valid, 0);
      k = 0;
      while (popped.size() == 0 && k < 10) begin cycle(1, 1, 0, '0); k++; end
      chk("t3a_first_pc", pop_at(0), 8'h20);

      // Latency 3, redirect to 0x40 with two requests in flight
      lat = 3;
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
      cycle(1, 1, 0, '0);
      cycle(1, 1, 0, '0);
      chk("t3b_inflight", mq.size(), 2);
      cycle(1, 1, 1, 8'h40);
      popped.delete();
      cycle(1, 1, 0, '0);
      chk("t3b_valid_after_redirect", s_valid, 0);
      k = 0;
      while (popped.size() < 2 && k < 20) begin cycle(1, 1, 0, '0); k++; end
      chk("t3b_first_pc", pop_at(0), 8'h40);
      chk("t3b_second_pc", pop_at(1), 8'h41);

      // Back-to-back redirects 0x40 then 0x80 with two in flight
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, '0);
      cycle(1, 1, 0, '0);
      cycle(1, 1, 0, '0);
      chk("t4_inflight", mq.size(), 2);
      cycle(1, 1, 1, 8'h40);
      cycle(1, 1, 1, 8'h80);
      chk("t4_state_drain", dut.state_q == StDrain, 1);
      popped.delete();
      for (int i = 0; i < 12; i++) cycle(1, 1, 0, '0);
      n_old = 0;
      foreach (popped[i]) if (popped[i] >= 8'h40 && popped[i] < 8'h80) n_old++;
      chk("t4_first_pc", pop_at(0), 8'h80);
      chk("t4_old_words_seen", n_old, 0);
      chk("t4_drop_cnt", dut.drop_cnt_q, 0);
      chk("t4_state_run", dut.state_q == StRun, 1);

      // PC wrap at the top of the address space
      lat = 1;
      cycle(1, 1, 1, 8'hFE);
      popped.delete();
      for (int i = 0; i < 8; i++) cycle(1, 1, 0, '0);
      chk("t5_pc_fe", pop_at(0), 8'hFE);
      chk("t5_pc_ff", pop_at(1), 8'hFF);
      chk("t5_pc_wrap", pop_at(2), 8'h00);

      // Random traffic against the model
      gnt_rand = 1; salt = 32'hC0DE_0000;
      for (int i = 0; i < 1500; i++) begin
         lat  = $urandom_range(1, 4);
         spur = ($urandom_range(0, 19) == 0);
         cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 24) == 0, AW'($urandom));
      end
      spur = 0; gnt_rand = 0; lat = 1;

      // Asynchronous reset mid-stream with the FIFO full
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, '0);
      #2;
      RST = 1'b1;
      #1;
      chk("t6_im_req", im_req, 0);
      chk("t6_im_addr", im_addr, RESET_PC);
      chk("t6_instr", instr, 0);
      chk("t6_instr_pc", instr_pc, 0);
      chk("t6_instr_valid", instr_valid, 0);
      mq.delete(); fq.delete(); issue_pc = RESET_PC;
      im_rvalid = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      cyc++;
      cycle(1, 1, 0, '0);
      chk("t6_first_req", s_req, 1);
      chk("t6_first_addr", s_addr, RESET_PC);
      for (int i = 0; i < 6; i++) cycle(1, 1, 0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
